// File: rtl/gmii_pkg.sv
// Shared definitions for the GMII inter-frame-gap monitor: FSM encoding and
// preamble/SFD constants.
package gmii_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StData,
    StGap
  } mon_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE         = 8'hD5;
  localparam int unsigned MAX_PREAMBLE_LEN = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/gmii_ifg_monitor.sv
// GMII frame/inter-frame-gap monitor: frame, gap-violation, error counters and gap/length stats.
// Build option: define GMII_IFG_MON_PREAMBLE_CHECK_EN to enable preamble/SFD checking.
module gmii_ifg_monitor
  import gmii_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [7:0]           gmii_d_in,
  input  logic                 gmii_en_in,
  input  logic                 gmii_er_in,
  input  logic [LEN_WIDTH-1:0] min_ifg,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] gap_viol_cnt,
  output logic [CNT_WIDTH-1:0] er_frame_cnt,
  output logic [CNT_WIDTH-1:0] preamble_err_cnt,
  output logic [LEN_WIDTH-1:0] last_ifg,
  output logic [LEN_WIDTH-1:0] min_ifg_seen,
  output logic [LEN_WIDTH-1:0] last_frame_len,
  output logic                 frame_done
);

`ifdef GMII_IFG_MON_PREAMBLE_CHECK_EN
  localparam logic PreambleCheck = 1'b1;
`else
  localparam logic PreambleCheck = 1'b0;
`endif

  localparam int unsigned          PreCntW    = $clog2(MAX_PREAMBLE_LEN);
  localparam logic [PreCntW-1:0]   PreCntLast = PreCntW'(MAX_PREAMBLE_LEN - 1);

  logic [7:0]           d_q;
  logic                 en_q, er_q, armed_q;
  mon_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, gap_q, gap_d;
  logic [PreCntW-1:0]   pre_cnt_q, pre_cnt_d;
  logic                 pre_err_q, pre_err_d, er_seen_q, er_seen_d, skip_q, skip_d;
  logic [LEN_WIDTH-1:0] last_ifg_q, last_ifg_d, min_seen_q, min_seen_d;
  logic [LEN_WIDTH-1:0] last_len_q, last_len_d;
  logic                 frame_done_q;
  logic                 in_frame, start, frame_end, measure;
  logic                 pre_byte, sfd_byte, pre_room;
  logic                 viol_inc, er_inc, perr_inc;

  // en_q resets high so a frame already in flight at reset release is ignored until en drops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d_q     <= '0;
      en_q    <= 1'b1;
      er_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      d_q     <= gmii_d_in;
      en_q    <= gmii_en_in;
      er_q    <= gmii_er_in;
      armed_q <= armed_q | ~en_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    pre_byte  = (d_q == PREAMBLE_BYTE);
    sfd_byte  = (d_q == SFD_BYTE);
    pre_room  = (pre_cnt_q != PreCntLast);
    in_frame  = (state_q == StPreamble) || (state_q == StData);
    frame_end = in_frame && !en_q;
    start     = en_q && ((state_q == StGap) || ((state_q == StIdle) && armed_q));
    measure   = start && (state_q == StGap) && !skip_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StGap: begin
        if (start) state_d = (PreambleCheck && pre_byte) ? StPreamble : StData;
      end
      StPreamble: begin
        if (!en_q) state_d = StGap;
        else if (!(pre_byte && pre_room)) state_d = StData;
      end
      StData: begin
        if (!en_q) state_d = StGap;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    len_d      = len_q;
    gap_d      = gap_q;
    pre_cnt_d  = pre_cnt_q;
    pre_err_d  = pre_err_q;
    er_seen_d  = er_seen_q;
    skip_d     = skip_q;
    last_ifg_d = last_ifg_q;
    min_seen_d = min_seen_q;
    last_len_d = last_len_q;

    if (start) begin
      len_d     = LEN_WIDTH'(1);
      pre_cnt_d = PreCntW'(1);
      pre_err_d = PreambleCheck && !pre_byte;
      er_seen_d = er_q;
      skip_d    = 1'b0;
    end else if (in_frame && en_q) begin
      if (len_q != '1) len_d = len_q + LEN_WIDTH'(1);
      er_seen_d = er_seen_q | er_q;
      if (state_q == StPreamble) begin
        if (pre_byte && pre_room) pre_cnt_d = pre_cnt_q + PreCntW'(1);
        else if (!sfd_byte) pre_err_d = 1'b1;
      end
    end

    if (frame_end) begin
      gap_d      = LEN_WIDTH'(1);
      last_len_d = len_q;
    end else if ((state_q == StGap) && !en_q && (gap_q != '1)) begin
      gap_d = gap_q + LEN_WIDTH'(1);
    end

    if (measure) begin
      last_ifg_d = gap_q;
      if (gap_q < min_seen_q) min_seen_d = gap_q;
    end

    if (clear) begin
      last_ifg_d = '0;
      last_len_d = '0;
      min_seen_d = '1;
      skip_d     = 1'b1;
    end
  end

  always_comb begin
    viol_inc = measure && (gap_q < min_ifg);
    er_inc   = frame_end && er_seen_q;
    // Ending while still in the preamble means the SFD never arrived.
    perr_inc = frame_end && (pre_err_q || (state_q == StPreamble));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      len_q        <= '0;
      gap_q        <= '0;
      pre_cnt_q    <= '0;
      pre_err_q    <= 1'b0;
      er_seen_q    <= 1'b0;
      skip_q       <= 1'b1;
      last_ifg_q   <= '0;
      min_seen_q   <= '1;
      last_len_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      len_q        <= len_d;
      gap_q        <= gap_d;
      pre_cnt_q    <= pre_cnt_d;
      pre_err_q    <= pre_err_d;
      er_seen_q    <= er_seen_d;
      skip_q       <= skip_d;
      last_ifg_q   <= last_ifg_d;
      min_seen_q   <= min_seen_d;
      last_len_q   <= last_len_d;
      frame_done_q <= frame_end;
    end
  end

  sat_counter #(.Width(CNT_WIDTH)) u_frame_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc_i  (frame_end),
    .clr_i  (clear),
    .cnt_o  (frame_cnt)
  );

  sat_counter #(.Width(CNT_WIDTH)) u_gap_viol_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc_i  (viol_inc),
    .clr_i  (clear),
    .cnt_o  (gap_viol_cnt)
  );

  sat_counter #(.Width(CNT_WIDTH)) u_er_frame_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc_i  (er_inc),
    .clr_i  (clear),
    .cnt_o  (er_frame_cnt)
  );

`ifdef GMII_IFG_MON_PREAMBLE_CHECK_EN
  sat_counter #(.Width(CNT_WIDTH)) u_preamble_err_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc_i  (perr_inc),
    .clr_i  (clear),
    .cnt_o  (preamble_err_cnt)
  );
`else
  logic unused_perr;
  assign unused_perr      = perr_inc;
  assign preamble_err_cnt = '0;
`endif

  assign last_ifg       = last_ifg_q;
  assign min_ifg_seen   = min_seen_q;
  assign last_frame_len = last_len_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_gmii_ifg_monitor.sv
// Directed bench: per-frame expectations are queued when a frame is driven and checked
// at each frame_done; a narrow second instance covers counter and length saturation.
module tb_gmii_ifg_monitor;

`ifdef GMII_IFG_MON_PREAMBLE_CHECK_EN
  localparam bit PreChk = 1'b1;
`else
  localparam bit PreChk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  d;
  logic        en, er, clear;
  logic [15:0] min_ifg;
  logic [3:0]  min_ifg_s;

  logic [31:0] frame_cnt, gap_viol_cnt, er_frame_cnt, preamble_err_cnt;
  logic [15:0] last_ifg, min_ifg_seen, last_frame_len;
  logic        frame_done;

  logic [1:0]  frame_cnt_s, gap_viol_cnt_s, er_frame_cnt_s, preamble_err_cnt_s;
  logic [3:0]  last_ifg_s, min_ifg_seen_s, last_frame_len_s;
  logic        frame_done_s;

  always #5 clk = ~clk;

  gmii_ifg_monitor dut (
    .clk              (clk),
    .resetn           (resetn),
    .gmii_d_in        (d),
    .gmii_en_in       (en),
    .gmii_er_in       (er),
    .min_ifg          (min_ifg),
    .clear            (clear),
    .frame_cnt        (frame_cnt),
    .gap_viol_cnt     (gap_viol_cnt),
    .er_frame_cnt     (er_frame_cnt),
    .preamble_err_cnt (preamble_err_cnt),
    .last_ifg         (last_ifg),
    .min_ifg_seen     (min_ifg_seen),
    .last_frame_len   (last_frame_len),
    .frame_done       (frame_done)
  );

  gmii_ifg_monitor #(.CNT_WIDTH(2), .LEN_WIDTH(4)) dut_s (
    .clk              (clk),
    .resetn           (resetn),
    .gmii_d_in        (d),
    .gmii_en_in       (en),
    .gmii_er_in       (er),
    .min_ifg          (min_ifg_s),
    .clear            (clear),
    .frame_cnt        (frame_cnt_s),
    .gap_viol_cnt     (gap_viol_cnt_s),
    .er_frame_cnt     (er_frame_cnt_s),
    .preamble_err_cnt (preamble_err_cnt_s),
    .last_ifg         (last_ifg_s),
    .min_ifg_seen     (min_ifg_seen_s),
    .last_frame_len   (last_frame_len_s),
    .frame_done       (frame_done_s)
  );

  typedef struct {
    int unsigned len, ifg, mins, frames, viol, er, perr;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done_prev = 1'b0;

  int unsigned m_frames, m_viol, m_er, m_perr, m_ifg, m_min, prev_gap;
  bit          have_gap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_frames = 0; m_viol = 0; m_er = 0; m_perr = 0; m_ifg = 0;
    m_min = 32'hFFFF; have_gap = 1'b0; prev_gap = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_gap_viol_cnt"}, gap_viol_cnt, 0);
    chk({tag, "_er_frame_cnt"}, er_frame_cnt, 0);
    chk({tag, "_preamble_err_cnt"}, preamble_err_cnt, 0);
    chk({tag, "_last_ifg"}, last_ifg, 0);
    chk({tag, "_min_ifg_seen"}, min_ifg_seen, 16'hFFFF);
    chk({tag, "_last_frame_len"}, last_frame_len, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_s_frame_cnt"}, frame_cnt_s, 0);
    chk({tag, "_s_min_ifg_seen"}, min_ifg_seen_s, 4'hF);
  endtask

  // Drives one frame (npre bytes of 0x55, then sfd, then random data) followed by gap idles.
  task automatic send_frame(input int len, input int npre, input logic [7:0] sfd,
                            input int er_n, input int gap, input bit clr_end);
    exp_t e;
    bit   perr;
    perr = PreChk && !((npre >= 1) && (npre <= 7) && (sfd == 8'hD5) && (len >= npre + 1));
    if (have_gap) begin
      m_ifg = prev_gap;
      if (prev_gap < m_min) m_min = prev_gap;
      if (prev_gap < 32'(min_ifg)) m_viol++;
    end
    m_frames++;
    if (er_n > 0) m_er++;
    if (perr) m_perr++;
    e.len = clr_end ? 0 : len;
    if (clr_end) begin
      model_reset();
    end else begin
      have_gap = 1'b1;
      prev_gap = gap;
    end
    e.ifg = m_ifg; e.mins = m_min; e.frames = m_frames;
    e.viol = m_viol; e.er = m_er; e.perr = m_perr;
    sb.push_back(e);

    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      en = 1'b1;
      er = (i >= 2) && (i < 2 + er_n);
      if (i < npre) d = 8'h55;
      else if (i == npre) d = sfd;
      else d = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      en = 1'b0; er = 1'b0; d = 8'h00;
      clear = clr_end && (i == 1);
    end
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (done_prev) chk("frame_done_width", frame_done, 0);
    if (frame_done) begin
      chk("sb_has_entry_at_done", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("last_frame_len", last_frame_len, e.len);
        chk("frame_cnt", frame_cnt, e.frames);
        chk("last_ifg", last_ifg, e.ifg);
        chk("min_ifg_seen", min_ifg_seen, e.mins);
        chk("gap_viol_cnt", gap_viol_cnt, e.viol);
        chk("er_frame_cnt", er_frame_cnt, e.er);
        chk("preamble_err_cnt", preamble_err_cnt, e.perr);
      end
    end
    done_prev = frame_done;
  end

  initial begin
    d = 8'h00; en = 1'b0; er = 1'b0; clear = 1'b0;
    min_ifg = 16'd12; min_ifg_s = 4'd12; resetn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(72, 7, 8'hD5, 0, 12, 1'b0);
    send_frame(72, 7, 8'hD5, 0, 12, 1'b0);
    chk("s_frame_cnt_at_max_minus_1", frame_cnt_s, 2);
    chk("s_last_frame_len_sat", last_frame_len_s, 4'hF);
    chk("s_last_ifg", last_ifg_s, 12);

    send_frame(64, 7, 8'hD5, 0, 8, 1'b0);
    send_frame(64, 7, 8'hD5, 0, 20, 1'b0);
    send_frame(64, 7, 8'hD5, 3, 12, 1'b0);
    chk("s_frame_cnt_sat", frame_cnt_s, 3);
    chk("s_last_ifg_sat", last_ifg_s, 4'hF);
    chk("s_gap_viol_cnt", gap_viol_cnt_s, 1);
    chk("s_min_ifg_seen", min_ifg_seen_s, 8);

    send_frame(64, 6, 8'hD4, 0, 12, 1'b0);
    send_frame(1, 7, 8'hD5, 0, 12, 1'b0);
    send_frame(40, 8, 8'hD5, 0, 12, 1'b0);
    chk("s_frame_cnt_stays_sat", frame_cnt_s, 3);
    send_frame(60, 1, 8'hD5, 0, 12, 1'b0);

    send_frame(50, 7, 8'hD5, 0, 12, 1'b1);
    chk("s_frame_cnt_clear_wins", frame_cnt_s, 0);
    send_frame(50, 7, 8'hD5, 0, 10, 1'b0);
    send_frame(50, 7, 8'hD5, 1, 12, 1'b0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      en = 1'b1;
      d  = (i < 7) ? 8'h55 : 8'($urandom_range(0, 255));
    end
    resetn = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      en = 1'b1;
      d  = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      en = 1'b0;
      d  = 8'h00;
    end
    send_frame(50, 7, 8'hD5, 0, 12, 1'b0);

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
